// File: rtl/fetch_pkg.sv
// Shared constants and the buffered fetch entry type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH      = 2;
  localparam int unsigned WORD_SHIFT       = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Oldest-first FIFO of fetched {pc, word} entries with push, pop and synchronous flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush wins over push and pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect flush; FETCH_PREFETCH_EN enables a DEPTH-deep
// prefetch window, otherwise one word is buffered or in flight at a time.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_act,
  output logic        mem_ldr,
  output logic        mem_str,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_valout,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned BUF_DEPTH = DEPTH;
`else
  localparam int unsigned BUF_DEPTH = (DEPTH > 1) ? 1 : DEPTH;
`endif
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          drop;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  fetch_entry_t  head;
  fetch_entry_t  ret_entry;
  logic          pop;
  logic          push;
  logic          issue;

  assign pop = !empty && instr_ready;

  // Issue credit counts in-flight words so the buffer cannot overflow.
`ifdef FETCH_PREFETCH_EN
  assign issue = rst_n && !br_valid &&
                 ((32'(count) + 32'(inflight)) < (BUF_DEPTH + 32'(pop)));
`else
  assign issue = rst_n && !br_valid && (count == '0) && !inflight;
`endif

  // A return arriving during a redirect belongs to the old stream and is discarded.
  assign push      = inflight && !drop && !br_valid && (!full || pop);
  assign ret_entry = '{pc: inflight_pc, instr: mem_valout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
    end else begin
      inflight <= issue;
      drop     <= br_valid && inflight;
      if (issue) inflight_pc <= pc;
      if (br_valid)   pc <= {br_target[31:2], 2'b00};
      else if (issue) pc <= pc + 32'd4;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ret_entry),
    .pop       (pop),
    .flush     (br_valid),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign mem_act     = issue;
  assign mem_ldr     = issue;
  assign mem_str     = 1'b0;
  assign mem_addr    = pc >> WORD_SHIFT;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule
